// File: rtl/regfile_multiport_if.sv
// regfile_multiport_if: write, read, clear and dump signals of the multiport register file
interface regfile_multiport_if #(
    parameter int NB_DATA = 32,
    parameter int NB_ADDR = 5,
    parameter int NUM_RD  = 2
);
    logic                      i_we;
    logic [NB_ADDR-1:0]        i_wr_addr;
    logic [NB_DATA-1:0]        i_wr_data;
    logic [NUM_RD*NB_ADDR-1:0] i_rd_addr;
    logic [NUM_RD*NB_DATA-1:0] o_rd_data;
    logic                      i_clear;
    logic                      i_dump_start;
    logic                      o_busy;
    logic                      o_dump_valid;
    logic                      i_dump_ready;
    logic [NB_ADDR-1:0]        o_dump_addr;
    logic [NB_DATA-1:0]        o_dump_data;
    logic                      o_dump_last;

    modport master (
        output i_we, i_wr_addr, i_wr_data, i_rd_addr, i_clear, i_dump_start, i_dump_ready,
        input  o_rd_data, o_busy, o_dump_valid, o_dump_addr, o_dump_data, o_dump_last
    );

    modport slave (
        input  i_we, i_wr_addr, i_wr_data, i_rd_addr, i_clear, i_dump_start, i_dump_ready,
        output o_rd_data, o_busy, o_dump_valid, o_dump_addr, o_dump_data, o_dump_last
    );
endinterface

// File: rtl/regfile_multiport.sv
// regfile_multiport: DLX GPR file, one write port, NUM_RD combinational reads, clear sweep and
// valid/ready register dump. Define REGFILE_BYPASS_EN for same-cycle write-to-read forwarding.
module regfile_multiport #(
    parameter int NB_DATA  = 32,
    parameter int NB_ADDR  = 5,
    parameter int NUM_RD   = 2,
    parameter bit ZERO_REG = 1'b1
) (
    input logic                clk,
    input logic                i_reset,
    regfile_multiport_if.slave rf
);
    localparam int DEPTH = 2 ** NB_ADDR;
    localparam logic [NB_ADDR:0] LAST = (NB_ADDR + 1)'(DEPTH - 1);
`ifdef REGFILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, CLEAR, DUMP} state_t;

    state_t             state_q, state_d;
    logic [NB_ADDR:0]   cnt_q, cnt_d;
    logic               dump_valid_q, dump_valid_d;
    logic [NB_DATA-1:0] dump_data_q, dump_data_d;
    logic [NB_DATA-1:0] regs_q [DEPTH];
    logic [NB_DATA-1:0] regs_d [DEPTH];
    logic [NB_ADDR-1:0] cnt_idx;
    logic               wr_ok;

    assign cnt_idx = cnt_q[NB_ADDR-1:0];
    assign wr_ok   = rf.i_we && state_q != CLEAR && !(ZERO_REG && rf.i_wr_addr == '0);

    // Combinational read ports, optionally forwarding the write that commits on the next edge
    always_comb begin
        rf.o_rd_data = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            rf.o_rd_data[k*NB_DATA +: NB_DATA] =
                (ZERO_REG && rf.i_rd_addr[k*NB_ADDR +: NB_ADDR] == '0) ? '0 :
                (BYPASS && wr_ok && rf.i_wr_addr == rf.i_rd_addr[k*NB_ADDR +: NB_ADDR]) ? rf.i_wr_data :
                regs_q[rf.i_rd_addr[k*NB_ADDR +: NB_ADDR]];
        end
    end

    // Next-state: register writes, clear sweep and dump sequencing
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        dump_valid_d = dump_valid_q;
        dump_data_d  = dump_data_q;
        regs_d       = regs_q;
        if (wr_ok) regs_d[rf.i_wr_addr] = rf.i_wr_data;
        if (state_q == IDLE) begin
            cnt_d = '0;
            if (rf.i_clear) begin
                state_d = CLEAR;
            end else if (rf.i_dump_start) begin
                state_d      = DUMP;
                dump_valid_d = 1'b1;
                dump_data_d  = regs_q[0];
            end
        end else if (state_q == CLEAR) begin
            regs_d[cnt_idx] = '0;
            cnt_d           = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
            state_d         = (cnt_q == LAST) ? IDLE : CLEAR;
        end else if (rf.i_dump_ready) begin
            if (cnt_q == LAST) begin
                state_d      = IDLE;
                cnt_d        = '0;
                dump_valid_d = 1'b0;
            end else begin
                cnt_d       = cnt_q + 1'b1;
                dump_data_d = regs_q[cnt_idx + 1'b1];
            end
        end
    end

    // State and register array, asynchronously zeroed
    always_ff @(posedge clk or posedge i_reset) begin
        if (i_reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            dump_valid_q <= 1'b0;
            dump_data_q  <= '0;
            regs_q       <= '{default: '0};
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            dump_valid_q <= dump_valid_d;
            dump_data_q  <= dump_data_d;
            regs_q       <= regs_d;
        end
    end

    assign rf.o_busy       = state_q != IDLE;
    assign rf.o_dump_valid = dump_valid_q;
    assign rf.o_dump_addr  = dump_valid_q ? cnt_idx : '0;
    assign rf.o_dump_data  = dump_data_q;
    assign rf.o_dump_last  = dump_valid_q && cnt_q == LAST;
endmodule
